// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output path: default sizes, the complex
// sample layout and the index bit-reversal helper.
package fft_pkg;

  localparam int DATA_W_DEF = 34;
  localparam int N_LOG2_DEF = 4;

  // One complex sample: [33:17] real, [16:0] imaginary, two's complement.
  typedef struct packed {
    logic signed [16:0] re;
    logic signed [16:0] im;
  } cplx_t;

  // Reverses the low 'width' bits of idx; bits above width come back as 0.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width) r[i] = idx[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_bank.sv
// One frame of sample storage: N x DATA_W registers, one synchronous write
// port and one combinational read port. Contents are never reset; the
// owner's full flags decide whether anything here is meaningful.
module fft_bitrev_bank
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [N_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [N_LOG2-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**N_LOG2];

  // Store the incoming sample at its (already reordered) address.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_buf.sv
// Ping-pong reorder buffer behind the FFT core: frames arrive in bit-reversed
// index order, are written to their natural positions, and are replayed in
// natural order at one sample per clock.
// Optional build macro FFT_BITREV_SOP_CHK_EN adds the in_sop input and the
// sticky sop_err flag, and realigns the write counter on start-of-frame.
module fft_bitrev_buf
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef FFT_BITREV_SOP_CHK_EN
  input  logic              in_sop,
  output logic              sop_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop
);

  localparam logic [N_LOG2-1:0] LAST = N_LOG2'((2**N_LOG2) - 1);

  logic              wb, rb;
  logic [1:0]        full;
  logic [N_LOG2-1:0] wcnt, rcnt;
  logic              accept, wr_en, wr_wrap;
  logic [N_LOG2-1:0] wr_idx, wcnt_nxt, waddr;
  logic              advance, rd_load, rd_last;
  logic [1:0]        set_m, clr_m;
  logic [DATA_W-1:0] rdata [2];
`ifdef FFT_BITREV_SOP_CHK_EN
  logic              sop_bad;
`endif

  // Ready depends only on state, never on in_valid.
  assign in_ready = !full[wb];
  assign accept   = in_valid && in_ready;

  // Decide what an accepted sample does to the frame being filled.
  always_comb begin
    wr_en    = accept;
    wr_idx   = wcnt;
    wcnt_nxt = wcnt + 1'b1;
`ifdef FFT_BITREV_SOP_CHK_EN
    sop_bad  = 1'b0;
    if (accept && in_sop && wcnt != '0) begin
      // Early start-of-frame: abandon the partial frame, restart at index 0.
      wr_idx   = '0;
      wcnt_nxt = N_LOG2'(1);
      sop_bad  = 1'b1;
    end else if (accept && !in_sop && wcnt == '0) begin
      // A frame may only begin on a marked sample; drop this one.
      wr_en    = 1'b0;
      wcnt_nxt = wcnt;
      sop_bad  = 1'b1;
    end
`endif
  end

  assign waddr   = N_LOG2'(bitrev(16'(wr_idx), N_LOG2));
  assign wr_wrap = wr_en && (wr_idx == LAST);

  assign advance = out_ready || !out_valid;
  assign rd_load = advance && full[rb];
  assign rd_last = rd_load && (rcnt == LAST);

  // Fill and drain always touch different banks, so both masks apply together.
  assign set_m = wr_wrap ? (2'b01 << wb) : 2'b00;
  assign clr_m = rd_last ? (2'b01 << rb) : 2'b00;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_bitrev_bank #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) u_bank (
      .clk   (clk),
      .we    (wr_en && (wb == 1'(g))),
      .waddr (waddr),
      .wdata (in_data),
      .raddr (rcnt),
      .rdata (rdata[g])
    );
  end

  // Write side: sample counter, fill bank pointer and per-bank full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb   <= 1'b0;
      wcnt <= '0;
      full <= 2'b00;
    end else begin
      if (accept)  wcnt <= wcnt_nxt;
      if (wr_wrap) wb   <= ~wb;
      full <= (full | set_m) & ~clr_m;
    end
  end

  // Read side: registered output stage replaying the full bank in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb        <= 1'b0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (advance) begin
      if (full[rb]) begin
        out_valid <= 1'b1;
        out_data  <= rdata[rb];
        out_sop   <= (rcnt == '0);
        out_eop   <= (rcnt == LAST);
        rcnt      <= rcnt + 1'b1;
        if (rcnt == LAST) rb <= ~rb;
      end else begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
    end
  end

`ifdef FFT_BITREV_SOP_CHK_EN
  // Framing error flag holds until reset.
  always_ff @(posedge clk) begin
    if (rst)          sop_err <= 1'b0;
    else if (sop_bad) sop_err <= 1'b1;
  end
`endif

endmodule

// File: doc/fft_bitrev_buf.md
# fft_bitrev_buf

Output reorder stage placed directly downstream of the `fft` core. The core emits each N-point frame of 34-bit complex samples in bit-reversed index order. This block writes every sample to its bit-reversed address in a ping-pong buffer and replays the frame in natural order toward the output pads. The two banks let one frame drain while the next fills, so throughput is sustained at one sample per clock.

## Interface
- `N_LOG2`, 4: log2 of frame length; N = 2**N_LOG2 samples per frame.
- `DATA_W`, 34: sample width; [33:17] real, [16:0] imaginary, both two's complement, passed through untouched.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the `fft` core presents a sample.
- `in_ready`  out  1  block accepts the sample this cycle.
- `in_data`  in  DATA_W  sample, bit-reversed order within the frame.
- `in_sop`  in  1  first sample of a frame (present only with `FFT_BITREV_SOP_CHK_EN`).
- `out_valid`  out  1  `out_data` holds a valid sample.
- `out_ready`  in  1  downstream consumes the sample.
- `out_data`  out  DATA_W  sample, natural order.
- `out_sop` / `out_eop`  out  1 each  natural index 0 / index N-1 marker, qualified by `out_valid`.
- `sop_err`  out  1  sticky misalignment flag (present only with `FFT_BITREV_SOP_CHK_EN`).

## Operation
- Storage: two banks of N x DATA_W. Write bank pointer `wb`, read bank pointer `rb`, per-bank `full[1:0]` flags, write counter `wcnt`, read counter `rcnt` (both N_LOG2 bits).
- Reset: `wb`=`rb`=0, `full`=0, `wcnt`=`rcnt`=0.
- Reset values of outputs: `out_valid`=0, `out_data`=0, `out_sop`=0, `out_eop`=0, `sop_err`=0, `in_ready`=1.
- Write side:
  - `in_ready` = !`full[wb]`.
  - On `in_valid && in_ready`, `in_data` is written to `bank[wb][bitrev(wcnt)]` and `wcnt` increments.
  - When `wcnt` wraps from N-1 to 0, `full[wb]` is set and `wb` toggles.
- Read side:
  - Each bank is EMPTY (!full), then FULL, then DRAINING.
  - An output register advances when `out_ready || !out_valid`.
  - On advance with `full[rb]` set: load `bank[rb][rcnt]`, set `out_valid`, set `out_sop` = (rcnt==0) and `out_eop` = (rcnt==N-1), then increment `rcnt`.
  - When the N-1 sample is loaded, clear `full[rb]` and toggle `rb`.
  - On advance with `full[rb]` clear: `out_valid` goes to 0.
- Simultaneous events:
  - Setting full on one bank and clearing it on the other in the same cycle both take effect.
  - A bank cleared this cycle may be written starting next cycle.
- Both banks full: `in_ready`=0 until the draining bank loads its last sample.
- Reset mid-operation discards all partial and full frames. No stale sample is emitted after reset.

## Timing
- Latency: last input sample accepted in cycle t → `full` set at t+1 → first output (natural index 0) valid at t+2, assuming `out_ready`=1 and the read side idle.
- Steady state with `out_ready`=1: one sample per cycle in and out, with no bubbles between frames.
- `out_data`, `out_valid` and the markers are registered. `in_ready` is combinational from the `full` and `wb` registers only, with no path from `in_valid`.
- `out_valid` never drops while a sample is held and `out_ready`=0.

## Configuration
- `FFT_BITREV_SOP_CHK_EN` defined: the `in_sop` and `sop_err` ports exist.
  - An accepted `in_sop` with `wcnt`≠0 sets `sop_err` (sticky until `rst`), resets `wcnt` to 0, and writes that sample as index 0 of the current bank. The partial frame is discarded.
  - An accepted sample with `wcnt`==0 and `in_sop`=0 is dropped and sets `sop_err`.
- Not defined: the ports are absent and framing is purely by sample count.

## Structure
- Shared package `fft_pkg`: `DATA_W`, `N_LOG2` defaults, the complex sample typedef (re/im fields), and a `bitrev` function.
- One sub-module, `fft_bitrev_bank`: a single N x DATA_W register array with write port and combinational read, instantiated twice.

## Test plan
- N=16, frame with values 0..15 fed in bit-reversed order (0,8,4,12,…), `out_ready`=1 → output is 0..15 in order; `out_sop` on 0, `out_eop` on 15; first output 2 cycles after the last input.
- Back-to-back frames, `in_valid` held high for 4 frames → no `in_ready` deassertion; 64 consecutive outputs with no gaps.
- `out_ready`=0 for 40 cycles during streaming → `in_ready` falls after two frames are buffered; no sample is lost or duplicated after release.
- `rst` asserted mid-frame while one bank is full → all outputs at 0 next cycle; the next complete frame is emitted correctly and no old data appears.
- With `FFT_BITREV_SOP_CHK_EN`: `in_sop` at sample 5 → `sop_err`=1 and the next 16 samples form one correct output frame. A non-SOP first sample is dropped.
- `out_ready` toggled every cycle → output sequence unchanged and each sample is held stable while `out_ready`=0.
